sine_phase_sequencer: RTL and testbench

- Sequences the quarter-wave sine lookup that drives the 10-bit R-2R DAC pins.
- Generates a sample-rate tick from the system clock and advances a phase accumulator on each tick.
- Issues folded (mirrored) addresses and read strobes to an external 1-cycle-latency quarter-wave magnitude ROM, and reconstructs the signed, offset 10-bit DAC code.
- Applies run-time frequency/rate reconfiguration glitch-free, at the phase wrap point.

---
 rtl/sine_phase_sequencer_if.sv | 29 ++
 rtl/sine_phase_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sine_phase_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_phase_sequencer_if.sv
// Bundle for the sine sequencer: run enable, config handshake, ROM port and DAC output.
// master = system/test side, slave = sequencer.
interface sine_phase_sequencer_if #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 7,
  parameter int DIV_W   = 8
);
  logic               en;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_step;
  logic [DIV_W-1:0]   cfg_div;
  logic               rom_rd;
  logic [ADDR_W-1:0]  rom_addr;
  logic [8:0]         rom_data;
  logic [9:0]         sample;
  logic               sample_valid;
  logic               wrap;

  modport master (
    output en, cfg_valid, cfg_step, cfg_div, rom_data,
    input  cfg_ready, rom_rd, rom_addr, sample, sample_valid, wrap
  );

  modport slave (
    input  en, cfg_valid, cfg_step, cfg_div, rom_data,
    output cfg_ready, rom_rd, rom_addr, sample, sample_valid, wrap
  );
endinterface

// File: rtl/sine_phase_sequencer.sv
// Quarter-wave sine sequencer: tick divider, phase accumulator, folded ROM addressing
// and offset DAC code reconstruction, with reconfiguration deferred to the phase wrap.
//
//   state | meaning
//   IDLE  | no ticks; configs load directly into step/div
//   RUN   | ticking; configs park in the pending slot until a carrying tick
module sine_phase_sequencer #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 7,
  parameter int DIV_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sine_phase_sequencer_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] pstep_q, pstep_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   pdiv_q, pdiv_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               configured_q, configured_d;
  logic               pending_q, pending_d;
  logic [1:0]         quad_q, quad_d;
  logic               rd_q, rd_d;
  logic               wrap_q, wrap_d;
  logic [9:0]         sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;

  logic               tick;
  logic               carry;
  logic               accept;
  logic [PHASE_W-1:0] phase_sum;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx;

  assign accept = bus.cfg_valid & ~pending_q;
  assign quad   = phase_q[PHASE_W-1 -: 2];
  assign idx    = phase_q[PHASE_W-3 -: ADDR_W];
  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, step_q};
  // en low wins over a coincident terminal count
  assign tick   = (state_q == ST_RUN) & bus.en & (div_cnt_q == div_q);

  assign bus.cfg_ready    = ~pending_q;
  assign bus.rom_rd       = tick;
  assign bus.rom_addr     = quad[0] ? ~idx : idx;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.wrap         = wrap_q;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    step_d         = step_q;
    pstep_d        = pstep_q;
    div_d          = div_q;
    pdiv_d         = pdiv_q;
    div_cnt_d      = div_cnt_q;
    configured_d   = configured_q;
    pending_d      = pending_q;
    quad_d         = quad_q;
    rd_d           = 1'b0;
    wrap_d         = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          step_d       = bus.cfg_step;
          div_d        = bus.cfg_div;
          configured_d = 1'b1;
        end
        // preload the terminal count so the first tick lands in the entry cycle
        if (bus.en && configured_q) begin
          state_d   = ST_RUN;
          div_cnt_d = div_d;
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          state_d   = ST_IDLE;
          phase_d   = '0;
          div_cnt_d = '0;
          sample_d  = 10'd512;
          if (pending_q) begin
            step_d    = pstep_q;
            div_d     = pdiv_q;
            pending_d = 1'b0;
          end else if (accept) begin
            step_d = bus.cfg_step;
            div_d  = bus.cfg_div;
          end
        end else begin
          if (accept) begin
            pending_d = 1'b1;
            pstep_d   = bus.cfg_step;
            pdiv_d    = bus.cfg_div;
          end
          if (rd_q) begin
            sample_d = quad_q[1] ? (10'd511 - {1'b0, bus.rom_data})
                                 : (10'd512 + {1'b0, bus.rom_data});
          end
          sample_valid_d = rd_q;
          if (tick) begin
            phase_d   = phase_sum;
            quad_d    = quad;
            rd_d      = 1'b1;
            wrap_d    = carry;
            div_cnt_d = '0;
            if (carry && pending_q) begin
              step_d    = pstep_q;
              div_d     = pdiv_q;
              pending_d = 1'b0;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      step_q         <= '0;
      pstep_q        <= '0;
      div_q          <= '0;
      pdiv_q         <= '0;
      div_cnt_q      <= '0;
      configured_q   <= 1'b0;
      pending_q      <= 1'b0;
      quad_q         <= 2'd0;
      rd_q           <= 1'b0;
      wrap_q         <= 1'b0;
      sample_q       <= 10'd512;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      step_q         <= step_d;
      pstep_q        <= pstep_d;
      div_q          <= div_d;
      pdiv_q         <= pdiv_d;
      div_cnt_q      <= div_cnt_d;
      configured_q   <= configured_d;
      pending_q      <= pending_d;
      quad_q         <= quad_d;
      rd_q           <= rd_d;
      wrap_q         <= wrap_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Scoreboard bench for sine_phase_sequencer: directed stimulus queues expected ROM
// addresses, samples and wrap points; a negedge monitor pops and compares them.
module tb_sine_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sine_phase_sequencer_if bus ();

  sine_phase_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: mode 0 returns the address, mode 1 returns 100 at address 0 else 511
  int rom_mode = 0;
  always @(posedge clk) begin
    if (bus.rom_rd) begin
      if (rom_mode == 0) bus.rom_data <= 9'(bus.rom_addr);
      else               bus.rom_data <= (bus.rom_addr == 7'd0) ? 9'd100 : 9'd511;
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {int addr; int gap;} rd_exp_t;
  typedef struct {int val; int idx;}  smp_exp_t;
  rd_exp_t  exp_rd[$];
  smp_exp_t exp_smp[$];
  int       exp_wrap[$];
  int       exp_ticks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // gap: expected cycles since previous read strobe (0 = don't care); samp<0: no sample
  task automatic push_tick(int addr, int gap, int samp, bit carry);
    exp_ticks++;
    exp_rd.push_back('{addr, gap});
    if (samp >= 0) exp_smp.push_back('{samp, exp_ticks});
    if (carry) exp_wrap.push_back(exp_ticks);
  endtask

  // ticks starting at phase 0: per_q ticks per quadrant, address stride inc; data = address
  task automatic push_seq(int n, int inc, int per_q, int first_gap, int gap, bit drop_last);
    for (int k = 0; k < n; k++) begin
      int quad;
      int j;
      int a;
      int s;
      quad = (k / per_q) % 4;
      j    = k % per_q;
      a    = (quad % 2 == 0) ? j * inc : 127 - j * inc;
      s    = (quad < 2) ? 512 + a : 511 - a;
      push_tick(a, (k == 0) ? first_gap : gap, (drop_last && k == n - 1) ? -1 : s,
                ((k + 1) % (4 * per_q)) == 0);
    end
  endtask

  int cyc = 0;
  int rd_total = 0;
  int last_rd_cyc = 0;
  int rd_cyc[int];

  always @(negedge clk) begin
    rd_exp_t  e;
    smp_exp_t s;
    cyc++;
    if (bus.wrap) begin
      if (exp_wrap.size() == 0) chk("wrap_unexpected", 1, 0);
      else chk("wrap_tick_index", rd_total, exp_wrap.pop_front());
    end
    if (bus.rom_rd) begin
      rd_total++;
      rd_cyc[rd_total] = cyc;
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = exp_rd.pop_front();
        chk("rom_addr", int'(bus.rom_addr), e.addr);
        if (e.gap != 0) chk("rd_gap", cyc - last_rd_cyc, e.gap);
      end
      last_rd_cyc = cyc;
    end
    if (bus.sample_valid) begin
      if (exp_smp.size() == 0) chk("sample_unexpected", 1, 0);
      else begin
        s = exp_smp.pop_front();
        chk("sample", int'(bus.sample), s.val);
        chk("sample_latency", rd_cyc.exists(s.idx) ? cyc - rd_cyc[s.idx] : -1, 2);
      end
    end
  end

  task automatic clks(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(int step, int div);
    bus.cfg_valid = 1'b1;
    bus.cfg_step  = 16'(step);
    bus.cfg_div   = 8'(div);
  endtask

  task automatic start_run();
    clks(1);
    bus.cfg_valid = 1'b0;
    bus.en        = 1'b1;
    clks(1);
  endtask

  initial begin
    int hi;
    int rds;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_step  = '0;
    bus.cfg_div   = '0;
    clks(3);
    rst = 1'b0;
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_rom_rd", int'(bus.rom_rd), 0);
    chk("rst_sample", int'(bus.sample), 512);
    chk("rst_sample_valid", int'(bus.sample_valid), 0);
    chk("rst_wrap", int'(bus.wrap), 0);

    // 1: step 0x0400, tick every cycle; drop en on a would-be tick
    push_seq(130, 8, 16, 0, 1, 1);
    offer(16'h0400, 0);
    start_run();
    clks(130);
    bus.en = 1'b0;
    clks(1);
    chk("t1_idle_sample", int'(bus.sample), 512);
    chk("t1_idle_valid", int'(bus.sample_valid), 0);

    // 2: quadrant folding with step 0x4000
    rom_mode = 1;
    push_tick(0,   0, 612,  1'b0);
    push_tick(127, 1, 1023, 1'b0);
    push_tick(0,   1, 411,  1'b0);
    push_tick(127, 1, 0,    1'b1);
    push_tick(0,   1, 612,  1'b0);
    push_tick(127, 1, 1023, 1'b0);
    push_tick(0,   1, 411,  1'b0);
    push_tick(127, 1, -1,   1'b1);
    offer(16'h4000, 0);
    start_run();
    clks(8);
    bus.en = 1'b0;
    clks(1);
    rom_mode = 0;

    // 3: div=3, one tick per 4 cycles
    push_seq(6, 8, 16, 0, 4, 1);
    offer(16'h0400, 3);
    start_run();
    clks(21);
    bus.en = 1'b0;
    clks(1);

    // 4: mid-run reconfig 0x0400 -> 0x0800, applied at the carrying tick
    push_seq(64, 8, 16, 0, 1, 0);
    push_seq(36, 16, 8, 1, 1, 1);
    offer(16'h0400, 0);
    start_run();
    clks(10);
    offer(16'h0800, 0);
    chk("t4_ready_before_offer", int'(bus.cfg_ready), 1);
    clks(1);
    offer(16'h0100, 0);
    hi = 0;
    for (int i = 0; i < 52; i++) begin
      if (bus.cfg_ready) hi++;
      clks(1);
    end
    chk("t4_ready_high_while_pending", hi, 0);
    bus.cfg_valid = 1'b0;
    chk("t4_ready_on_wrap_tick", int'(bus.cfg_ready), 0);
    clks(1);
    chk("t4_ready_after_wrap", int'(bus.cfg_ready), 1);
    clks(36);
    bus.en = 1'b0;
    clks(1);

    // 5: en dropped with a sample in flight, then re-enabled
    push_seq(3, 8, 16, 0, 4, 1);
    push_seq(4, 8, 16, 0, 4, 0);
    offer(16'h0400, 3);
    start_run();
    clks(9);
    bus.en = 1'b0;
    clks(1);
    chk("t5_drop_sample", int'(bus.sample), 512);
    chk("t5_drop_valid", int'(bus.sample_valid), 0);
    chk("t5_drop_rom_rd", int'(bus.rom_rd), 0);
    bus.en = 1'b1;
    clks(1);
    clks(14);
    bus.en = 1'b0;
    clks(1);

    // 6: reset with a config pending and en held high
    push_tick(0, 0, 512, 1'b0);
    offer(16'h0400, 3);
    start_run();
    clks(1);
    offer(16'h0800, 0);
    clks(1);
    bus.cfg_valid = 1'b0;
    chk("t6_ready_pending", int'(bus.cfg_ready), 0);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    chk("t6_rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("t6_rst_rom_rd", int'(bus.rom_rd), 0);
    chk("t6_rst_sample", int'(bus.sample), 512);
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rom_rd) rds++;
      clks(1);
    end
    chk("t6_rd_while_unconfigured", rds, 0);
    push_seq(4, 8, 16, 0, 1, 1);
    offer(16'h0400, 0);
    clks(1);
    bus.cfg_valid = 1'b0;
    clks(1);
    clks(4);
    bus.en = 1'b0;
    clks(5);

    chk("left_rd_expectations", exp_rd.size(), 0);
    chk("left_sample_expectations", exp_smp.size(), 0);
    chk("left_wrap_expectations", exp_wrap.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
